// File: rtl/arcade_video_pkg.sv
// Shared video types and helpers: the pause/dim state set and the per-channel
// brightness scale used by the fader and other video blocks.
package arcade_video_pkg;

    typedef enum logic [2:0] {
        RUN,
        WAIT,
        FADE_DN,
        DIM,
        FADE_UP
    } fader_state_t;

    // out = (pix * (2^lb - level)) >> lb. The 32-bit product is exact while
    // pix is at most 16 bits and lb at most 15 bits.
    function automatic logic [31:0] rgb_scale(input logic [15:0]   pix,
                                              input logic [15:0]   level,
                                              input int unsigned   lb);
        logic [31:0] gain;
        gain = (32'd1 << lb) - {16'd0, level};
        return ({16'd0, pix} * gain) >> lb;
    endfunction

endpackage

// File: rtl/pause_fader_rgb_attenuate.sv
// CH-channel brightness attenuator: combinational scale per channel,
// then one output register.
module rgb_attenuate
    import arcade_video_pkg::*;
#(
    parameter int CW = 4,
    parameter int CH = 3,
    parameter int LB = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [LB-1:0]    i_level,
    input  logic [CH*CW-1:0] i_rgb,
    output logic [CH*CW-1:0] o_rgb
);

    logic [CH*CW-1:0] w_scaled;
    logic [CH*CW-1:0] r_rgb;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        assign w_scaled[c*CW +: CW] = CW'(rgb_scale(16'(i_rgb[c*CW +: CW]), 16'(i_level), LB));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_scaled;
        end
    end

    assign o_rgb = r_rgb;

endmodule

// File: rtl/pause_fader.sv
// Pause merge (button toggle + external request) and idle screen dimmer that
// fades the picture down after a pause timeout and back up on wake.
module pause_fader
    import arcade_video_pkg::*;
#(
    parameter int CW          = 4,
    parameter int CH          = 3,
    parameter int DIM_CYCLES  = 32'h7270E00,
    parameter int STEP_CYCLES = 4096,
    parameter int LB          = 4,
    parameter int DIM_MAX     = 8
) (
    input  logic                           clk_sys,
    input  logic                           reset,
    input  logic                           pause_btn,
    input  logic                           pause_req,
    input  logic                           activity,
    input  logic [CH*CW-1:0]               rgb_in,
    output logic                           pause,
    output logic [CH*CW-1:0]               rgb_out,
    output logic [$clog2(DIM_MAX+1)-1:0]   dim_level,
    output logic                           dimmed
);

    localparam int TW  = (DIM_CYCLES > 1) ? $clog2(DIM_CYCLES) : 1;
    localparam int SW  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int LVW = $clog2(DIM_MAX + 1);

    localparam logic [TW-1:0]  TIMER_LAST = TW'(DIM_CYCLES - 1);
    localparam logic [SW-1:0]  STEP_LAST  = SW'(STEP_CYCLES - 1);
    localparam logic [LVW-1:0] LEVEL_TOP  = LVW'(DIM_MAX);
    localparam logic [LVW-1:0] LEVEL_PRE  = LVW'(DIM_MAX - 1);

    fader_state_t   r_state;
    logic           r_btn_q;
    logic           r_toggle;
    logic           r_pause;
    logic [TW-1:0]  r_timer;
    logic [SW-1:0]  r_step;
    logic [LVW-1:0] r_level;

    logic w_btn_rise;
    logic w_pause;
    logic w_wake;

    assign w_btn_rise = pause_btn & ~r_btn_q;
    // The FSM acts on the same value that is being registered into pause, so
    // the fade reacts on the very edge the pause output changes.
    assign w_pause    = r_toggle | pause_req;
    assign w_wake     = ~w_pause | activity;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_btn_q  <= 1'b1;
            r_toggle <= 1'b0;
            r_pause  <= 1'b0;
            r_state  <= RUN;
            r_timer  <= '0;
            r_step   <= '0;
            r_level  <= '0;
        end else begin
            r_btn_q <= pause_btn;
            r_pause <= w_pause;
            if (w_btn_rise) begin
                r_toggle <= ~r_toggle;
            end

            case (r_state)
                RUN: begin
                    r_level <= '0;
                    r_timer <= '0;
                    r_step  <= '0;
                    if (w_pause) begin
                        r_state <= WAIT;
                    end
                end

                WAIT: begin
                    if (!w_pause) begin
                        r_state <= RUN;
                        r_timer <= '0;
                    end else if (activity) begin
                        r_timer <= '0;
                    end else if (r_timer == TIMER_LAST) begin
                        r_state <= FADE_DN;
                        r_step  <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                FADE_DN: begin
                    if (w_wake) begin
                        r_state <= FADE_UP;
                        r_timer <= '0;
                        r_step  <= '0;
                    end else if (r_step == STEP_LAST) begin
                        r_step  <= '0;
                        r_level <= r_level + LVW'(1);
                        if (r_level == LEVEL_PRE) begin
                            r_state <= DIM;
                        end
                    end else begin
                        r_step <= r_step + SW'(1);
                    end
                end

                DIM: begin
                    if (w_wake) begin
                        r_state <= FADE_UP;
                        r_timer <= '0;
                        r_step  <= '0;
                    end
                end

                FADE_UP: begin
                    // A re-pause here only changes where the ramp ends up.
                    if (r_level == '0) begin
                        r_state <= w_pause ? WAIT : RUN;
                        r_timer <= '0;
                        r_step  <= '0;
                    end else if (r_step == STEP_LAST) begin
                        r_step  <= '0;
                        r_level <= r_level - LVW'(1);
                        if (r_level == LVW'(1)) begin
                            r_state <= w_pause ? WAIT : RUN;
                            r_timer <= '0;
                        end
                    end else begin
                        r_step <= r_step + SW'(1);
                    end
                end

                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    rgb_attenuate #(
        .CW (CW),
        .CH (CH),
        .LB (LB)
    ) u_att (
        .i_clk   (clk_sys),
        .i_reset (reset),
        .i_level (LB'(r_level)),
        .i_rgb   (rgb_in),
        .o_rgb   (rgb_out)
    );

    assign pause     = r_pause;
    assign dim_level = r_level;
    assign dimmed    = (r_level == LEVEL_TOP);

endmodule

// File: tb/tb_pause_fader.sv
// Directed scenario bench for pause_fader with random pixel data, checked
// against a timeline model of the fade level and the pause merge rules.
module tb_pause_fader;

    localparam int T_DIM  = 16;
    localparam int T_STEP = 4;
    localparam int T_MAX  = 8;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        pause_btn;
    logic        pause_req;
    logic        activity;
    logic [11:0] rgb_in;
    logic        pause;
    logic [11:0] rgb_out;
    logic [3:0]  dim_level;
    logic        dimmed;

    pause_fader #(
        .CW          (4),
        .CH          (3),
        .DIM_CYCLES  (T_DIM),
        .STEP_CYCLES (T_STEP),
        .LB          (4),
        .DIM_MAX     (T_MAX)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .pause_btn (pause_btn),
        .pause_req (pause_req),
        .activity  (activity),
        .rgb_in    (rgb_in),
        .pause     (pause),
        .rgb_out   (rgb_out),
        .dim_level (dim_level),
        .dimmed    (dimmed)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: level is a function of time since an anchor edge.
    // mode 0: level 0; mode 1: dimming timeline from anchor (idle timer 0 there);
    // mode 2: fade up from m_L at anchor, then re-dim if still paused.
    int m_mode   = 0;
    int m_anchor = 0;
    int m_L      = 0;
    bit m_paused = 0;
    int m_lvl    = 0;
    bit m_tog    = 0;
    bit m_btnq   = 1;
    bit m_pause  = 0;
    bit force_white = 0;

    function automatic int dimfn(int t);
        int k;
        if (t < T_DIM + T_STEP) return 0;
        k = (t - T_DIM - T_STEP) / T_STEP + 1;
        return (k > T_MAX) ? T_MAX : k;
    endfunction

    function automatic int upfn(int t, int L, bit p);
        if (t < T_STEP * L) return L - t / T_STEP;
        return p ? dimfn(t - T_STEP * L) : 0;
    endfunction

    function automatic logic [11:0] ref_scale(logic [11:0] px, int lvl);
        logic [11:0] r;
        int ch;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            ch = (int'(px[c*4 +: 4]) * (16 - lvl)) / 16;
            r[c*4 +: 4] = 4'(ch);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_mode(input int mode, input bit paused);
        m_mode   = mode;
        m_anchor = cyc + 1;
        m_L      = m_lvl;
        m_paused = paused;
    endtask

    task automatic step();
        logic [11:0] d;
        int  plvl;
        bit  prst, pb, pr;
        d      = force_white ? 12'hFFF : 12'($urandom);
        rgb_in = d;
        plvl   = m_lvl;
        prst   = reset;
        pb     = pause_btn;
        pr     = pause_req;
        @(posedge clk_sys);
        #1;
        cyc++;
        if (prst) begin
            m_tog = 0; m_btnq = 1; m_pause = 0; m_mode = 0; m_lvl = 0;
        end else begin
            m_pause = m_tog | pr;
            if (pb && !m_btnq) m_tog = ~m_tog;
            m_btnq = pb;
            case (m_mode)
                1:       m_lvl = dimfn(cyc - m_anchor);
                2:       m_lvl = upfn(cyc - m_anchor, m_L, m_paused);
                default: m_lvl = 0;
            endcase
        end
        check("rgb_out", 32'(rgb_out), prst ? 32'd0 : 32'(ref_scale(d, plvl)));
        check("dim_level", 32'(dim_level), 32'(m_lvl));
        check("dimmed", 32'(dimmed), 32'(m_lvl == T_MAX));
        check("pause", 32'(pause), 32'(m_pause));
    endtask

    initial begin
        int p2;
        reset     = 1'b1;
        pause_btn = 1'b1;
        pause_req = 1'b0;
        activity  = 1'b0;
        rgb_in    = '0;
        repeat (4) step();
        check("reset_pause", 32'(pause), 32'd0);
        check("reset_rgb", 32'(rgb_out), 32'd0);

        // Button held through reset release must not toggle.
        reset = 1'b0;
        repeat (6) step();
        check("held_btn_no_toggle", 32'(pause), 32'd0);
        pause_btn = 1'b0;
        repeat (3) step();

        // Press for three cycles; pause two clocks after the press.
        pause_btn = 1'b1;
        step();
        check("pause_not_yet", 32'(pause), 32'd0);
        set_mode(1, 1);
        step();
        check("pause_2clk", 32'(pause), 32'd1);
        step();
        pause_btn = 1'b0;
        while (cyc < m_anchor + 19) step();
        check("lvl0_before_first_step", 32'(dim_level), 32'd0);
        step();
        check("lvl1_at_20", 32'(dim_level), 32'd1);
        while (cyc < m_anchor + 48) step();
        check("lvl8_at_48", 32'(dim_level), 32'd8);
        check("dimmed_at_48", 32'(dimmed), 32'd1);
        force_white = 1;
        step();
        check("white_half", 32'(rgb_out), 32'h777);
        force_white = 0;
        repeat (5) step();

        // Activity wakes the dimmed screen; it fades up then re-dims.
        activity = 1'b1;
        set_mode(2, 1);
        step();
        activity = 1'b0;
        while (cyc < m_anchor + 32) step();
        check("woke_to_zero", 32'(dim_level), 32'd0);
        p2 = m_anchor + 32;
        while (cyc < p2 + 28) step();
        check("redim_lvl3", 32'(dim_level), 32'd3);

        // Second press while fading down at level 3: unpause and ramp to RUN.
        pause_btn = 1'b1;
        step();
        set_mode(2, 0);
        step();
        check("unpause_drop", 32'(pause), 32'd0);
        step();
        pause_btn = 1'b0;
        repeat (35) step();
        check("run_after_unpause", 32'(dim_level), 32'd0);

        // External request pulse of five cycles, no dimming.
        pause_req = 1'b1;
        repeat (5) step();
        pause_req = 1'b0;
        repeat (20) step();

        // Activity coincident with the timeout restarts the idle wait.
        pause_req = 1'b1;
        set_mode(1, 1);
        step();
        while (cyc < m_anchor + 15) step();
        activity = 1'b1;
        set_mode(1, 1);
        step();
        activity = 1'b0;
        check("timeout_blocked", 32'(dim_level), 32'd0);
        while (cyc < m_anchor + 36) step();
        check("lvl5_before_reset", 32'(dim_level), 32'd5);

        // Reset mid-fade.
        reset = 1'b1;
        step();
        check("midfade_reset_lvl", 32'(dim_level), 32'd0);
        check("midfade_reset_rgb", 32'(rgb_out), 32'd0);
        check("midfade_reset_pause", 32'(pause), 32'd0);
        reset     = 1'b0;
        pause_req = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pause_fader.md
# pause_fader

Parametrised pause and screen-dim controller for arcade cores, placed between the core's RGB output and the video pipeline in the `clk_sys` domain. It merges a user pause button (toggle on press) with an external pause request into one `pause` output for the core. After a configurable idle time in pause, it fades the picture down to a programmable dim level in steps. It fades back up on unpause or on player activity.

## Interface
Parameters:
- `CW`, 4: bits per colour channel.
- `CH`, 3: number of colour channels, packed MSB-first (R,G,B).
- `DIM_CYCLES`, 32'h7270E00: cycles in pause before fading starts (~10 s @ 12 MHz).
- `STEP_CYCLES`, 4096: cycles between successive fade steps (≥1).
- `LB`, 4: attenuation resolution in bits.
- `DIM_MAX`, 8: final attenuation level (1..2^LB−1); 8 with LB=4 gives half brightness.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `pause_btn` in 1: user pause button, level.
- `pause_req` in 1: external pause request, level (e.g. OSD open).
- `activity` in 1: any player input; wakes a dimmed screen.
- `rgb_in` in CH*CW: core pixel data.
- `pause` out 1: pause to core, registered.
- `rgb_out` out CH*CW: attenuated pixel data, registered.
- `dim_level` out $clog2(DIM_MAX+1): current attenuation level.
- `dimmed` out 1: high while level == DIM_MAX.

## Operation
- Edge detect: `btn_q <= pause_btn`. The toggle flips on `pause_btn & ~btn_q`. After reset `btn_q` = 1, so a button held through reset does not toggle.
- `pause = toggle | pause_req`, registered.
- States:
  - `RUN`: level 0, idle timer 0. Go to `WAIT` when `pause` is high.
  - `WAIT`: idle timer increments each cycle. When timer == DIM_CYCLES−1, go to `FADE_DN`.
  - `FADE_DN`: step counter counts to STEP_CYCLES−1, then level+1 and the counter clears. Go to `DIM` when level reaches DIM_MAX.
  - `DIM`: hold at DIM_MAX.
  - `FADE_UP`: level−1 every STEP_CYCLES cycles. At level 0, go to `WAIT` if `pause` is still high, otherwise `RUN`.
- Unpause (`pause` low) in `WAIT`: go to `RUN`.
- Unpause in `FADE_DN` or `DIM`: go to `FADE_UP`. The `pause` output drops the same cycle, independent of the fade.
- `activity` while paused in `WAIT`: clear the idle timer.
- `activity` while paused in `FADE_DN` or `DIM`: go to `FADE_UP`, clearing the idle timer and step counter.
- Re-pause while in `FADE_UP`: continue fading up, then go to `WAIT` with the timer at 0.
- Attenuation, per channel: `out = (in * (2^LB − level)) >> LB`. The product is CW+LB+1 bits wide and the result is truncated to CW bits. Level 0 is the exact pass-through.
- `dim_level` and `dimmed` reflect the registered level.

## Timing
- Reset values: `pause`=0, toggle=0, `rgb_out`=0, `dim_level`=0, `dimmed`=0, state `RUN`, all counters 0.
- Reset applies mid-fade: the level returns to 0 on the next cycle.
- `pause` rises 1 cycle after the sampled button edge, i.e. 2 clocks after the input rises.
- `pause` follows `pause_req` with 1-cycle latency.
- `rgb_out` has 1 cycle latency from `rgb_in` and uses the level registered in the same cycle.
- The first fade step lands DIM_CYCLES + STEP_CYCLES cycles after `pause` rises.
- Full fade takes DIM_MAX × STEP_CYCLES cycles.
- Simultaneous `activity` and timeout in the same cycle: `activity` wins, the timer clears and there is no transition.
- Simultaneous unpause and `activity`: unpause handling applies.
- Counters saturate and never wrap.
- The timer width is $clog2(DIM_CYCLES).

## Structure
- Shared package `arcade_video_pkg`: the state enum (`RUN`, `WAIT`, `FADE_DN`, `DIM`, `FADE_UP`) and a `rgb_scale` function, reused by other video blocks.
- One sub-module: `rgb_attenuate`, a CH-channel combinational scale plus output register, parametrised on CW/CH/LB.
- The FSM, counters and edge detect live in `pause_fader`.

## Test plan
- Defaults with `STEP_CYCLES`=4 and `DIM_CYCLES`=16; press `pause_btn` for 3 cycles → `pause` high 2 clocks after the press. `dim_level` reaches 1 at cycle 20 after `pause` and 8 at cycle 48. `rgb_in`=0xFFF → `rgb_out`=0x777.
- Hold `pause_btn` high through reset release → no toggle; `pause` stays 0.
- While `DIM`, pulse `activity` for 1 cycle → level steps 8→0 every 4 cycles, state `WAIT`, timer 0. Redims after another 16 + 32 cycles.
- While `FADE_DN` at level 3, second button press → `pause` drops 1 cycle after the sampled edge, level ramps 3→0 and the state ends in `RUN`.
- `pause_req` pulse 5 cycles, toggle 0 → `pause` high for exactly 5 cycles, no dimming. `activity` together with timeout at cycle 15 → no level change.
- Reset asserted at level 5 → next cycle `dim_level`=0, `rgb_out`=0, `pause`=0.
